inst_fetch_unit: RTL and testbench
==================================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, meaning byte-address width of the PC and the programming port.
REQ-002 Parameter INST_BYTES, default 4, meaning bytes per instruction word, which is also the PC step.
REQ-003 Parameter DEPTH, default 64, meaning instruction slots; MEM_BYTES = DEPTH*INST_BYTES, which SHALL be at most 2^ADDR_W.
REQ-004 Port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port i_prog_en, input, 1 bit: programming mode request; 1 = memory programmable, 0 = core may run.
REQ-007 Port i_prog_we, input, 1 bit: byte write strobe, honoured only in PROG.
REQ-008 Port i_prog_addr, input, ADDR_W bits: programming byte address.
REQ-009 Port i_prog_data, input, 8 bits: programming write byte.
REQ-010 Port o_prog_rdata, output, 8 bits: readback byte for the programming port.
REQ-011 Port i_run, input, 1 bit: run enable.
REQ-012 Port i_branch_en, input, 1 bit: redirect request.
REQ-013 Port i_branch_target, input, ADDR_W bits: byte address of the redirect.
REQ-014 Port i_ready, input, 1 bit: downstream accepts o_inst.
REQ-015 Port o_valid, output, 1 bit: o_inst and o_pc hold a fetched instruction.
REQ-016 Port o_inst, output, 8*INST_BYTES bits: instruction, little-endian (byte at lowest address in bits [7:0]).
REQ-017 Port o_pc, output, ADDR_W bits: byte address of o_inst.
REQ-018 Port o_state, output, 2 bits: IDLE=0, PROG=1, RUN=2, HALT=3.
REQ-019 Port o_fault, output, 1 bit: sticky fault flag.

Function
REQ-020 Storage SHALL be a MEM_BYTES x 8 byte array; its contents SHALL NOT be cleared by reset.
REQ-021 IDLE transitions: i_prog_en=1 goes to PROG; otherwise i_run=1 goes to RUN; otherwise stay in IDLE.
REQ-022 PROG transitions: i_prog_en=0 goes to IDLE.
REQ-023 RUN transitions: i_prog_en=1 goes to PROG; otherwise fault goes to HALT; otherwise i_run=0 goes to IDLE.
REQ-024 HALT transitions: i_prog_en=1 goes to PROG; otherwise stay in HALT; i_run is ignored.
REQ-025 Priority each cycle: i_prog_en first, then fault, then i_run/branch.
REQ-026 Entering PROG: internal PC set to 0, o_valid cleared, o_fault cleared.
REQ-027 Leaving RUN for any state: o_valid cleared the same edge; no fetch that cycle.
REQ-028 PROG write: with i_prog_we=1 and i_prog_addr<MEM_BYTES, byte written at the edge; out-of-range writes ignored without fault.
REQ-029 PROG read: o_prog_rdata = mem[i_prog_addr] one cycle after the address is presented, for any state; 0 if out of range.
REQ-030 Read-during-write to the same address SHALL return the old byte.
REQ-031 Fetch rule in RUN: when o_valid=0 or (o_valid & i_ready), load o_inst from mem[PC..PC+INST_BYTES-1], o_pc<=PC, o_valid<=1, PC<=PC+INST_BYTES.
REQ-032 First o_valid after entering RUN SHALL appear on the second edge in RUN (1-cycle fetch latency).
REQ-033 Stall: o_valid & !i_ready SHALL hold o_inst, o_pc and PC unchanged.
REQ-034 PC wrap: PC+INST_BYTES >= MEM_BYTES SHALL wrap PC to 0, with no fault.
REQ-035 Branch: sampled only in RUN on a handshake (o_valid & i_ready & i_branch_en); sets PC<=i_branch_target and o_valid<=0 (flush); the next fetch comes from the target.
REQ-036 i_branch_en without a handshake SHALL be ignored.
REQ-037 Branch fault: a target with target%INST_BYTES!=0 or target>=MEM_BYTES sets o_fault=1, o_valid=0, PC unchanged, next state HALT.

Reset
REQ-038 i_rst=1 at an edge SHALL set state IDLE, PC=0, o_valid=0, o_inst=0, o_pc=0, o_fault=0, o_prog_rdata=0.
REQ-039 Reset SHALL override all inputs, including mid-program and mid-fetch.
REQ-040 Memory contents SHALL survive reset.

Verification
REQ-041 Program: PROG, write bytes 0x11,0x22,0x33,0x44 at 0..3, then RUN with i_ready=1 -> o_inst=0x44332211, o_pc=0 on the 2nd RUN edge, then o_pc=4.
REQ-042 Stall: hold i_ready=0 for 5 cycles at o_pc=8 -> o_inst/o_pc stable, o_valid=1; release -> next o_pc=12.
REQ-043 Wrap: run to o_pc=252 (defaults) with i_ready=1 -> next o_pc=0, o_fault=0.
REQ-044 Branch: handshake with target 0x40 -> o_valid=0 for one cycle, then o_pc=0x40; target 0x41 -> o_fault=1, o_state=3.
REQ-045 Priority: i_prog_en=1 and i_run=1 asserted together from RUN -> o_state=1, o_valid=0, PC=0; readback of address 2 returns 0x33 one cycle later.
REQ-046 Reset mid-RUN at o_pc=20 -> all outputs 0, o_state=0; rerun -> first o_inst=0x44332211 (memory retained).

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: byte-programmable instruction store with an
// IDLE/PROG/RUN/HALT controller and a one-deep fetch output stage.
module inst_fetch_unit #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned INST_BYTES = 4,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_prog_en,
  input  logic                      i_prog_we,
  input  logic [ADDR_W-1:0]         i_prog_addr,
  input  logic [7:0]                i_prog_data,
  output logic [7:0]                o_prog_rdata,
  input  logic                      i_run,
  input  logic                      i_branch_en,
  input  logic [ADDR_W-1:0]         i_branch_target,
  input  logic                      i_ready,
  output logic                      o_valid,
  output logic [8*INST_BYTES-1:0]   o_inst,
  output logic [ADDR_W-1:0]         o_pc,
  output logic [1:0]                o_state,
  output logic                      o_fault
);

  localparam int unsigned MEM_BYTES = DEPTH * INST_BYTES;
  localparam int unsigned IDX_W     = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned INST_W    = 8 * INST_BYTES;
  localparam int unsigned EXT_W     = ADDR_W + 1;
  localparam logic [EXT_W-1:0] MEM_LIM = EXT_W'(MEM_BYTES);
  localparam logic [EXT_W-1:0] STEP    = EXT_W'(INST_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROG = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        mem [MEM_BYTES];

  logic [EXT_W-1:0]  pc_inc;
  logic [EXT_W-1:0]  tgt_ext;
  logic [ADDR_W-1:0] pc_next;
  logic              handshake;
  logic              tgt_bad;
  logic              prog_in_range;
  logic [INST_W-1:0] fetch_word;

  // Widened arithmetic so the wrap compare cannot overflow when MEM_BYTES == 2^ADDR_W.
  assign pc_inc        = {1'b0, pc} + STEP;
  assign pc_next       = (pc_inc >= MEM_LIM) ? '0 : pc_inc[ADDR_W-1:0];
  assign tgt_ext       = {1'b0, i_branch_target};
  assign tgt_bad       = ((tgt_ext % STEP) != '0) || (tgt_ext >= MEM_LIM);
  assign handshake     = o_valid & i_ready;
  assign prog_in_range = ({1'b0, i_prog_addr} < MEM_LIM);
  assign o_state       = state;

  // Little-endian gather; pc is always aligned and in range so no byte wraps.
  always_comb begin
    fetch_word = '0;
    for (int k = 0; k < int'(INST_BYTES); k++) begin
      fetch_word[8*k +: 8] = mem[IDX_W'(pc + ADDR_W'(k))];
    end
  end

  // Storage is deliberately not reset so a program survives i_rst.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (state == PROG) && i_prog_we && prog_in_range) begin
      mem[IDX_W'(i_prog_addr)] <= i_prog_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      pc           <= '0;
      o_valid      <= 1'b0;
      o_inst       <= '0;
      o_pc         <= '0;
      o_fault      <= 1'b0;
      o_prog_rdata <= '0;
    end else begin
      o_prog_rdata <= prog_in_range ? mem[IDX_W'(i_prog_addr)] : 8'h00;
      if (i_prog_en) begin
        state   <= PROG;
        pc      <= '0;
        o_valid <= 1'b0;
        o_fault <= 1'b0;
      end else begin
        case (state)
          IDLE: if (i_run) state <= RUN;
          PROG: state <= IDLE;
          RUN: begin
            if (handshake && i_branch_en && tgt_bad) begin
              o_fault <= 1'b1;
              o_valid <= 1'b0;
              state   <= HALT;
            end else if (!i_run) begin
              o_valid <= 1'b0;
              state   <= IDLE;
            end else if (handshake && i_branch_en) begin
              pc      <= i_branch_target;
              o_valid <= 1'b0;
            end else if (!o_valid || i_ready) begin
              o_inst  <= fetch_word;
              o_pc    <= pc;
              o_valid <= 1'b1;
              pc      <= pc_next;
            end
          end
          HALT:    state <= HALT;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit at default parameters.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        prog_en;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [7:0]  prog_rdata;
  logic        run;
  logic        branch_en;
  logic [7:0]  branch_target;
  logic        ready;
  logic        valid;
  logic [31:0] inst;
  logic [7:0]  pc;
  logic [1:0]  state;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  inst_fetch_unit dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_prog_en      (prog_en),
    .i_prog_we      (prog_we),
    .i_prog_addr    (prog_addr),
    .i_prog_data    (prog_data),
    .o_prog_rdata   (prog_rdata),
    .i_run          (run),
    .i_branch_en    (branch_en),
    .i_branch_target(branch_target),
    .i_ready        (ready),
    .o_valid        (valid),
    .o_inst         (inst),
    .o_pc           (pc),
    .o_state        (state),
    .o_fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic run_to_pc(input logic [7:0] target, input string tag);
    int n;
    n = 0;
    while (pc !== target && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(pc), 32'(target));
  endtask

  logic [7:0] first4 [4];

  initial begin
    first4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1; prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    run = 1'b0; branch_en = 1'b0; branch_target = '0; ready = 1'b1;
    step(); step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_inst",  inst,       32'd0);
    check("rst_pc",    32'(pc),    32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_rdata", 32'(prog_rdata), 32'd0);
    rst = 1'b0;

    // Fill memory: bytes 0..3 fixed, every other byte holds its own address.
    prog_en = 1'b1;
    step();
    check("prog_state", 32'(state), 32'd1);
    for (int a = 0; a < 256; a++) wr(8'(a), (a < 4) ? first4[a] : 8'(a));
    prog_addr = 8'd2;
    step();
    check("readback_2", 32'(prog_rdata), 32'h33);
    wr(8'd5, 8'hAA);
    check("rdw_old", 32'(prog_rdata), 32'h05);
    prog_addr = 8'd5;
    step();
    check("rdw_new", 32'(prog_rdata), 32'hAA);
    wr(8'd5, 8'h05);

    // Run and fetch.
    prog_en = 1'b0;
    step();
    check("idle_state", 32'(state), 32'd0);
    run = 1'b1; ready = 1'b1;
    step();
    check("run_state", 32'(state), 32'd2);
    check("run_lat_valid", 32'(valid), 32'd0);
    step();
    check("fetch0_valid", 32'(valid), 32'd1);
    check("fetch0_inst",  inst,       32'h44332211);
    check("fetch0_pc",    32'(pc),    32'd0);
    step();
    check("fetch1_pc",    32'(pc),    32'd4);
    check("fetch1_inst",  inst,       32'h07060504);
    step();
    check("fetch2_pc",    32'(pc),    32'd8);

    // Stall for five cycles at pc 8.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("stall_pc",    32'(pc),    32'd8);
    check("stall_inst",  inst,       32'h0B0A0908);
    check("stall_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    step();
    check("unstall_pc", 32'(pc), 32'd12);

    // Wrap at the top of memory.
    run_to_pc(8'd252, "wrap_reach");
    check("top_inst", inst, 32'hFFFEFDFC);
    step();
    check("wrap_pc",    32'(pc),    32'd0);
    check("wrap_inst",  inst,       32'h44332211);
    check("wrap_fault", 32'(fault), 32'd0);

    // Good branch flushes one slot.
    branch_en = 1'b1; branch_target = 8'h40;
    step();
    branch_en = 1'b0;
    check("br_flush_valid", 32'(valid), 32'd0);
    step();
    check("br_pc",   32'(pc),    32'h40);
    check("br_inst", inst,       32'h43424140);
    // Branch request without handshake is ignored.
    ready = 1'b0; branch_en = 1'b1; branch_target = 8'h80;
    step();
    check("br_nohs_pc", 32'(pc), 32'h40);
    branch_en = 1'b0; ready = 1'b1;
    step();
    check("br_nohs_next", 32'(pc), 32'h44);
    // Misaligned target faults into HALT.
    branch_en = 1'b1; branch_target = 8'h41;
    step();
    branch_en = 1'b0;
    check("brf_fault", 32'(fault), 32'd1);
    check("brf_state", 32'(state), 32'd3);
    check("brf_valid", 32'(valid), 32'd0);
    step();
    check("halt_stays", 32'(state), 32'd3);

    // Leave HALT through PROG, rerun, then prog_en+run together from RUN.
    prog_en = 1'b1;
    step();
    check("halt_prog_fault", 32'(fault), 32'd0);
    prog_en = 1'b0;
    step(); step(); step(); step();
    check("rerun_pc4", 32'(pc), 32'd4);
    prog_en = 1'b1; prog_addr = 8'd2;
    step();
    check("prio_state", 32'(state), 32'd1);
    check("prio_valid", 32'(valid), 32'd0);
    step();
    check("prio_rdata", 32'(prog_rdata), 32'h33);
    prog_en = 1'b0;
    step(); step(); step();
    check("prio_pc_zero", 32'(pc), 32'd0);

    // Reset mid-run keeps memory.
    run_to_pc(8'd20, "reach_20");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_state", 32'(state), 32'd0);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_inst",  inst,       32'd0);
    check("mrst_pc",    32'(pc),    32'd0);
    check("mrst_rdata", 32'(prog_rdata), 32'd0);
    step(); step();
    check("mrst_rerun_inst", inst,    32'h44332211);
    check("mrst_rerun_pc",   32'(pc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
